// File: rtl/aibcr3_dll_ctrl_pkg.sv
// Shared types and helpers for the DLL interpolator gray-code loop controller.
package aibcr3_dll_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, TRACK, SETTLE} dll_state_e;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  function automatic logic [2:0] bin2gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/aibcr3_dll_pd_filter.sv
// Up/down accumulator for phase-detector decisions; emits a step pulse on the
// same edge the accumulator would reach +/-2^(FILT_W-1).
module aibcr3_dll_pd_filter #(
  parameter int FILT_W = 3
) (
  input  logic CLKIN,
  input  logic RST,
  input  logic clr,
  input  logic pd_up,
  input  logic pd_dn,
  output logic step_up,
  output logic step_dn
);

  localparam logic [FILT_W:0] TH_P = (FILT_W+1)'(1) << (FILT_W-1);
  localparam logic [FILT_W:0] TH_N = (FILT_W+1)'(0) - TH_P;

  logic [FILT_W:0] acc, acc_nxt;

  always_comb begin
    acc_nxt = acc;
    if (pd_up && !pd_dn)      acc_nxt = acc + (FILT_W+1)'(1);
    else if (pd_dn && !pd_up) acc_nxt = acc - (FILT_W+1)'(1);
  end

  // Two's-complement compare; acc never leaves (-TH, +TH) so no overflow.
  assign step_up = !clr && (acc_nxt == TH_P);
  assign step_dn = !clr && (acc_nxt == TH_N);

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST)                            acc <= '0;
    else if (clr || step_up || step_dn) acc <= '0;
    else                                acc <= acc_nxt;
  end

endmodule

// File: rtl/aibcr3_dll_intp_gray_ctrl.sv
// DLL fine-phase loop controller: filtered up/down steps a 0..7 code driven out
// as gray, with coarse wrap requests, lock and saturation. AIBCR3_DLL_CTRL_OVRD_EN adds code override.
module aibcr3_dll_intp_gray_ctrl
  import aibcr3_dll_ctrl_pkg::*;
#(
  parameter int FILT_W     = 3,
  parameter int SETTLE_CYC = 4,
  parameter int LOCK_CNT   = 8,
  parameter int INIT_CODE  = 4
) (
  input  logic       CLKIN,
  input  logic       RST,
  input  logic       en,
  input  logic       pd_up,
  input  logic       pd_dn,
  input  logic       coarse_max,
  input  logic       coarse_min,
`ifdef AIBCR3_DLL_CTRL_OVRD_EN
  input  logic       ovrd_en,
  input  logic [2:0] ovrd_code,
`endif
  output logic [2:0] gray,
  output logic [2:0] fine_bin,
  output logic       inc_coarse,
  output logic       dec_coarse,
  output logic       locked,
  output logic       sat_err
);

  dll_state_e state;
  logic [3:0] settle_cnt;
  logic [3:0] rev_cnt;
  logic [1:0] last_dir;
  logic       ovrd, tracking, step_up, step_dn, step;
  logic [2:0] fine_nxt;
  logic       inc_nxt, dec_nxt, sat_hit;
  logic [1:0] step_dir;

`ifdef AIBCR3_DLL_CTRL_OVRD_EN
  assign ovrd = ovrd_en;
`else
  assign ovrd = 1'b0;
`endif

  assign tracking = en && !ovrd && (state == TRACK);
  assign step     = step_up || step_dn;
  assign step_dir = step_up ? DIR_UP : DIR_DN;

  aibcr3_dll_pd_filter #(.FILT_W(FILT_W)) u_filt (
    .CLKIN   (CLKIN),
    .RST     (RST),
    .clr     (!tracking),
    .pd_up   (pd_up),
    .pd_dn   (pd_dn),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  always_comb begin
    fine_nxt = fine_bin;
    inc_nxt  = 1'b0;
    dec_nxt  = 1'b0;
    sat_hit  = 1'b0;
    if (step_up) begin
      if (fine_bin != 3'd7)  fine_nxt = fine_bin + 3'd1;
      else if (!coarse_max) begin
        fine_nxt = 3'd0;
        inc_nxt  = 1'b1;
      end else sat_hit = 1'b1;
    end else if (step_dn) begin
      if (fine_bin != 3'd0)  fine_nxt = fine_bin - 3'd1;
      else if (!coarse_min) begin
        fine_nxt = 3'd7;
        dec_nxt  = 1'b1;
      end else sat_hit = 1'b1;
    end
`ifdef AIBCR3_DLL_CTRL_OVRD_EN
    if (ovrd_en) fine_nxt = ovrd_code;
`endif
  end

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      fine_bin   <= 3'(INIT_CODE);
      gray       <= bin2gray(3'(INIT_CODE));
      inc_coarse <= 1'b0;
      dec_coarse <= 1'b0;
      locked     <= 1'b0;
      sat_err    <= 1'b0;
      settle_cnt <= '0;
      rev_cnt    <= '0;
      last_dir   <= DIR_NONE;
    end else begin
      fine_bin   <= fine_nxt;
      gray       <= bin2gray(fine_nxt);
      inc_coarse <= inc_nxt;
      dec_coarse <= dec_nxt;
      if (!en || ovrd) begin
        state      <= IDLE;
        settle_cnt <= '0;
        rev_cnt    <= '0;
        locked     <= 1'b0;
        last_dir   <= DIR_NONE;
        if (!en) sat_err <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= TRACK;
          TRACK: if (step) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            last_dir   <= step_dir;
            if (sat_hit) sat_err <= 1'b1;
            // A reversal moves toward lock; a repeated direction means we are slewing.
            if (last_dir != DIR_NONE && last_dir != step_dir) begin
              if (rev_cnt != 4'd15) rev_cnt <= rev_cnt + 4'd1;
              if (rev_cnt >= 4'(LOCK_CNT - 1)) locked <= 1'b1;
            end else if (last_dir == step_dir) begin
              rev_cnt <= '0;
              locked  <= 1'b0;
            end
          end
          SETTLE: begin
            if (settle_cnt == 4'(SETTLE_CYC - 1)) begin
              state      <= TRACK;
              settle_cnt <= '0;
            end else settle_cnt <= settle_cnt + 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aibcr3_dll_intp_gray_ctrl.sv
// Directed table-driven bench for the DLL gray-code loop controller.
module tb_aibcr3_dll_intp_gray_ctrl;

  logic       CLKIN = 1'b0;
  logic       RST, en, pd_up, pd_dn, coarse_max, coarse_min;
  logic [2:0] gray, fine_bin;
  logic       inc_coarse, dec_coarse, locked, sat_err;
`ifdef AIBCR3_DLL_CTRL_OVRD_EN
  logic       ovrd_en = 1'b0;
  logic [2:0] ovrd_code = 3'd0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLKIN = ~CLKIN;

  aibcr3_dll_intp_gray_ctrl dut (
    .CLKIN      (CLKIN),
    .RST        (RST),
    .en         (en),
    .pd_up      (pd_up),
    .pd_dn      (pd_dn),
    .coarse_max (coarse_max),
    .coarse_min (coarse_min),
`ifdef AIBCR3_DLL_CTRL_OVRD_EN
    .ovrd_en    (ovrd_en),
    .ovrd_code  (ovrd_code),
`endif
    .gray       (gray),
    .fine_bin   (fine_bin),
    .inc_coarse (inc_coarse),
    .dec_coarse (dec_coarse),
    .locked     (locked),
    .sat_err    (sat_err)
  );

  typedef struct {
    logic       en, up, dn, cmax, cmin;
    int         n;
    logic [2:0] fine, gr;
    logic       inc, dec, lk, sat;
  } vec_t;

  vec_t       tbl[12];
  logic [2:0] gtab[8];

  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] f, input logic [2:0] g,
                       input logic inc, input logic dec, input logic lk, input logic sat);
    logic [9:0] got, exp;
    got = {fine_bin, gray, inc_coarse, dec_coarse, locked, sat_err};
    exp = {f, g, inc, dec, lk, sat};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: fine,gray,inc,dec,lk,sat got %b_%b_%b%b%b%b want %b_%b_%b%b%b%b", name,
               got[9:7], got[6:4], got[3], got[2], got[1], got[0],
               exp[9:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic d, input logic cx, input logic cn);
    en = e; pd_up = u; pd_dn = d; coarse_max = cx; coarse_min = cn;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    gtab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    //          en up dn cx cn   n  fine  gray   inc dec lk sat
    tbl[0]  = '{1, 1, 0, 0, 0,  4, 3'd4, 3'b110, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0,  8, 3'd5, 3'b111, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0,  8, 3'd6, 3'b101, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0,  8, 3'd7, 3'b100, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0,  1, 3'd0, 3'b000, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 0, 0,  7, 3'd0, 3'b000, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 0, 0,  1, 3'd7, 3'b100, 0, 1, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 0,  7, 3'd7, 3'b100, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 1, 0,  1, 3'd7, 3'b100, 0, 0, 0, 1};
    tbl[9]  = '{1, 1, 1, 1, 0, 20, 3'd7, 3'b100, 0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0,  1, 3'd7, 3'b100, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0,  2, 3'd7, 3'b100, 0, 0, 0, 0};

    RST = 1'b1;
    drive(0, 0, 0, 0, 0);
    #2;
    check("reset_state", 3'd4, 3'b110, 0, 0, 0, 0);
    tick();
    RST = 1'b0;
    tick();
    check("idle_hold", 3'd4, 3'b110, 0, 0, 0, 0);

    // Stepping, settle gaps, coarse wrap both ways, saturation, pd conflict, en=0 clear.
    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].en, tbl[r].up, tbl[r].dn, tbl[r].cmax, tbl[r].cmin);
      for (int c = 0; c < tbl[r].n; c++) begin
        tick();
        check($sformatf("tbl%0d_cyc%0d", r, c), tbl[r].fine, tbl[r].gr,
              tbl[r].inc, tbl[r].dec, tbl[r].lk, tbl[r].sat);
      end
    end

    // Lock: alternate directions until 8 reversals, then repeat a direction.
    do_reset();
    drive(1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0);
    repeat (4) tick();
    check("lock_s1", 3'd5, gtab[5], 0, 0, 0, 0);
    for (int k = 2; k <= 11; k++) begin
      logic       up;
      logic [2:0] f;
      up = (k % 2 == 1) || (k >= 10);
      f  = (k <= 9) ? ((k % 2 == 1) ? 3'd5 : 3'd4) : 3'(k - 4);
      drive(1, up, !up, 0, 0);
      repeat (7) tick();
      check($sformatf("lock_pre_s%0d", k), (k <= 10) ? ((k % 2 == 1) ? 3'd4 : 3'd5) : 3'd6,
            (k <= 10) ? ((k % 2 == 1) ? gtab[4] : gtab[5]) : gtab[6], 0, 0, (k == 10), 0);
      tick();
      check($sformatf("lock_s%0d", k), f, gtab[f], 0, 0, (k == 9), 0);
    end

    // Asynchronous reset in the middle of SETTLE.
    tick();
    tick();
    #2;
    RST = 1'b1;
    #1;
    check("async_rst", 3'd4, 3'b110, 0, 0, 0, 0);
    tick();
    RST = 1'b0;
    drive(1, 1, 0, 0, 0);
    repeat (4) tick();
    check("post_rst_idle", 3'd4, 3'b110, 0, 0, 0, 0);
    tick();
    check("post_rst_step", 3'd5, 3'b111, 0, 0, 0, 0);

`ifdef AIBCR3_DLL_CTRL_OVRD_EN
    ovrd_en = 1'b1;
    ovrd_code = 3'd2;
    tick();
    check("ovrd", 3'd2, 3'b011, 0, 0, 0, 0);
    ovrd_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
